// File: rtl/serial_parallel_rx_if.sv
// Bus bundle between the framed serial receiver and its driver/consumer.
// slave = receiver side, master = line driver plus word consumer.
interface serial_parallel_rx_if #(
    parameter int DATA_WIDTH = 14,
    parameter int LEN_WIDTH  = 4
);
    logic                  en;
    logic                  din;
    logic [LEN_WIDTH-1:0]  bit_lngth;
    logic                  lsb_first;
    logic                  dready;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dv_out;
    logic                  busy;
    logic                  overrun;
    logic                  parity_err;

    modport slave (
        input  en, din, bit_lngth, lsb_first, dready,
        output dout, dv_out, busy, overrun, parity_err
    );

    modport master (
        output en, din, bit_lngth, lsb_first, dready,
        input  dout, dv_out, busy, overrun, parity_err
    );
endinterface

// File: rtl/serial_parallel_rx.sv
// Framed serial-to-parallel receiver: start bit, N payload bits (MSB/LSB first), right-justified word.
// Latency: word valid N+2 cycles after the start-bit edge (N+3 with parity); one frame every N+2 cycles.
// Backpressure: single valid/ready output register; a frame completing while it is full is dropped with overrun.
// Optional even-parity bit enabled by SERIAL_PARALLEL_RX_PARITY_EN.
module serial_parallel_rx #(
    parameter int DATA_WIDTH = 14,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    serial_parallel_rx_if.slave  bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
`ifdef SERIAL_PARALLEL_RX_PARITY_EN
    localparam logic [1:0] S_PARITY = 2'd2;
`endif
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [LEN_WIDTH-1:0] LP_MAX = LEN_WIDTH'(DATA_WIDTH);
    localparam logic [LEN_WIDTH-1:0] LP_ONE = LEN_WIDTH'(1);

    logic [1:0]            r_state;
    logic [LEN_WIDTH-1:0]  r_cnt;
    logic [LEN_WIDTH-1:0]  r_len;
    logic                  r_lsb;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_dv;
    logic                  r_overrun;

    logic [LEN_WIDTH-1:0]  w_len;
    logic                  w_last;
    logic                  w_par_ok;
    logic [DATA_WIDTH-1:0] w_shift_nxt;

    // Zero and out-of-range lengths both mean a full-width frame.
    assign w_len  = (bus.bit_lngth == '0 || bus.bit_lngth > LP_MAX) ? LP_MAX : bus.bit_lngth;
    assign w_last = (r_cnt == r_len - LP_ONE);

    // LSB-first drops each bit at its final position; MSB-first shifts up so the first bit lands at N-1.
    always_comb begin
        w_shift_nxt = r_shift;
        if (r_lsb) begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                if (LEN_WIDTH'(i) == r_cnt) begin
                    w_shift_nxt[i] = bus.din;
                end
            end
        end else begin
            w_shift_nxt = {r_shift[DATA_WIDTH-2:0], bus.din};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_len     <= '0;
            r_lsb     <= 1'b0;
            r_shift   <= '0;
            r_dout    <= '0;
            r_dv      <= 1'b0;
            r_overrun <= 1'b0;
        end else if (!bus.en) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_len     <= '0;
            r_lsb     <= 1'b0;
            r_shift   <= '0;
            r_dout    <= '0;
            r_dv      <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (r_dv && bus.dready) begin
                r_dv <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (!bus.din) begin
                        r_state <= S_SHIFT;
                        r_cnt   <= '0;
                        r_shift <= '0;
                        r_len   <= w_len;
                        r_lsb   <= bus.lsb_first;
                    end
                end
                S_SHIFT: begin
                    r_shift <= w_shift_nxt;
                    r_cnt   <= r_cnt + LP_ONE;
                    if (w_last) begin
`ifdef SERIAL_PARALLEL_RX_PARITY_EN
                        r_state <= S_PARITY;
`else
                        r_state <= S_DONE;
`endif
                    end
                end
`ifdef SERIAL_PARALLEL_RX_PARITY_EN
                S_PARITY: begin
                    r_state <= S_DONE;
                end
`endif
                S_DONE: begin
                    r_state <= S_IDLE;
                    // A consumer taking the old word this cycle frees the register for the new one.
                    if (w_par_ok) begin
                        if (!r_dv || bus.dready) begin
                            r_dout <= r_shift;
                            r_dv   <= 1'b1;
                        end else begin
                            r_overrun <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SERIAL_PARALLEL_RX_PARITY_EN
    logic r_par;
    logic r_parity_err;

    // Running XOR over payload and parity bit; any residue at DONE is a mismatch.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_par        <= 1'b0;
            r_parity_err <= 1'b0;
        end else if (!bus.en) begin
            r_par        <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!bus.din) begin
                        r_par <= 1'b0;
                    end
                end
                S_SHIFT, S_PARITY: begin
                    r_par <= r_par ^ bus.din;
                end
                S_DONE: begin
                    r_parity_err <= r_par;
                end
                default: begin
                    r_par <= 1'b0;
                end
            endcase
        end
    end

    assign w_par_ok       = ~r_par;
    assign bus.parity_err = r_parity_err;
`else
    assign w_par_ok       = 1'b1;
    assign bus.parity_err = 1'b0;
`endif

    assign bus.dout    = r_dout;
    assign bus.dv_out  = r_dv;
    assign bus.busy    = (r_state != S_IDLE);
    assign bus.overrun = r_overrun;
endmodule

// File: tb/tb_serial_parallel_rx.sv
// Bench for serial_parallel_rx: directed scenarios plus randomized frames against a frame-level model.
module tb_serial_parallel_rx;
    localparam int DW   = 14;
    localparam int LW   = 4;
    localparam int MAXC = 1024;
`ifdef SERIAL_PARALLEL_RX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    serial_parallel_rx_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

    serial_parallel_rx #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    // Per-cycle stimulus and observations (observed #1 after the edge ending cycle c).
    logic          en_seq  [MAXC];
    logic          din_seq [MAXC];
    logic [LW-1:0] bl_seq  [MAXC];
    logic          lsb_seq [MAXC];
    logic          rdy_seq [MAXC];
    logic          obs_dv  [MAXC];
    logic [DW-1:0] obs_dout[MAXC];
    logic          obs_busy[MAXC];
    logic          obs_ovr [MAXC];
    logic          obs_perr[MAXC];

    logic          m_done  [MAXC];
    logic          m_bad   [MAXC];
    logic [DW-1:0] m_word  [MAXC];
    logic          m_busy  [MAXC];

    int n_vec;
    int n_err;

    function automatic int eff_len(input logic [LW-1:0] bl);
        if (bl == '0 || int'(bl) > DW) return DW;
        return int'(bl);
    endfunction

    // pat holds the wire order: pat[n-1] is the first payload bit sent.
    function automatic logic [DW-1:0] ref_word(input logic [DW-1:0] pat, input int n, input logic lsb);
        int acc;
        acc = 0;
        for (int k = 0; k < n; k++) begin
            if (pat[n-1-k]) acc += lsb ? (1 << k) : (1 << (n - 1 - k));
        end
        return DW'(acc);
    endfunction

    function automatic logic even_par(input logic [DW-1:0] pat, input int n);
        logic p;
        p = 1'b0;
        for (int k = 0; k < n; k++) p ^= pat[k];
        return p;
    endfunction

    task automatic clear_seq(input int n);
        for (int c = 0; c < n; c++) begin
            en_seq[c]  = (c != 0);
            din_seq[c] = 1'b1;
            bl_seq[c]  = LW'($urandom);
            lsb_seq[c] = 1'($urandom);
            rdy_seq[c] = 1'b0;
        end
    endtask

    task automatic put_frame(input int c0, input logic [LW-1:0] bl, input logic lsb,
                             input logic [DW-1:0] pat, input logic bad, output int d);
        int n;
        n = eff_len(bl);
        din_seq[c0] = 1'b0;
        bl_seq[c0]  = bl;
        lsb_seq[c0] = lsb;
        for (int k = 0; k < n; k++) din_seq[c0+1+k] = pat[n-1-k];
        if (P == 1) din_seq[c0+1+n] = even_par(pat, n) ^ bad;
        d = c0 + n + 1 + P;
    endtask

    task automatic run_seq(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            bus.en        = en_seq[c];
            bus.din       = din_seq[c];
            bus.bit_lngth = bl_seq[c];
            bus.lsb_first = lsb_seq[c];
            bus.dready    = rdy_seq[c];
            @(posedge clk);
            #1;
            obs_dv[c]   = bus.dv_out;
            obs_dout[c] = bus.dout;
            obs_busy[c] = bus.busy;
            obs_ovr[c]  = bus.overrun;
            obs_perr[c] = bus.parity_err;
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        bus.en = 1'b1; bus.din = 1'b0; bus.dready = 1'b0;
        @(negedge clk);
        bus.din = 1'b1;
        @(posedge clk);
        #1;
        n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL reset_prebusy got %b want 1", bus.busy); end
        #2 rstn = 1'b0;
        #1;
        n_vec++; if (bus.dout !== '0) begin n_err++; $display("FAIL reset_dout got %h want 0", bus.dout); end
        n_vec++; if (bus.dv_out !== 1'b0) begin n_err++; $display("FAIL reset_dv got %b want 0", bus.dv_out); end
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_vec++; if (bus.overrun !== 1'b0) begin n_err++; $display("FAIL reset_ovr got %b want 0", bus.overrun); end
        n_vec++; if (bus.parity_err !== 1'b0) begin n_err++; $display("FAIL reset_perr got %b want 0", bus.parity_err); end
        @(negedge clk);
        rstn = 1'b1;
        clear_seq(20);
        en_seq[0] = 1'b1;
        run_seq(20);
        for (int c = 0; c < 20; c++) begin
            n_vec++; if (obs_dv[c] !== 1'b0) begin n_err++; $display("FAIL idle_dv cyc %0d got %b want 0", c, obs_dv[c]); end
            n_vec++; if (obs_busy[c] !== 1'b0) begin n_err++; $display("FAIL idle_busy cyc %0d got %b want 0", c, obs_busy[c]); end
        end
    endtask

    task automatic test_msb_first;
        int d;
        clear_seq(30);
        put_frame(2, 4'd8, 1'b0, 14'h00B2, 1'b0, d);
        rdy_seq[d+5] = 1'b1;
        run_seq(30);
        n_vec++; if (obs_busy[2] !== 1'b1) begin n_err++; $display("FAIL msb_busy got %b want 1", obs_busy[2]); end
        n_vec++; if (obs_dv[d-1] !== 1'b0) begin n_err++; $display("FAIL msb_dv_early got %b want 0", obs_dv[d-1]); end
        n_vec++; if (obs_dv[d] !== 1'b1) begin n_err++; $display("FAIL msb_dv got %b want 1", obs_dv[d]); end
        n_vec++; if (obs_dout[d] !== 14'h00B2) begin n_err++; $display("FAIL msb_dout got %h want 00b2", obs_dout[d]); end
        n_vec++; if (obs_busy[d] !== 1'b0) begin n_err++; $display("FAIL msb_busy_end got %b want 0", obs_busy[d]); end
        n_vec++; if (obs_dv[d+4] !== 1'b1) begin n_err++; $display("FAIL msb_hold_dv got %b want 1", obs_dv[d+4]); end
        n_vec++; if (obs_dv[d+5] !== 1'b0) begin n_err++; $display("FAIL msb_consume_dv got %b want 0", obs_dv[d+5]); end
        n_vec++; if (obs_dout[d+5] !== 14'h00B2) begin n_err++; $display("FAIL msb_consume_dout got %h want 00b2", obs_dout[d+5]); end
    endtask

    task automatic test_lsb_clamp;
        int d1, d2, d3;
        logic [DW-1:0] pa, pb;
        logic la, lb;
        pa = DW'($urandom); pb = DW'($urandom);
        la = 1'($urandom);  lb = 1'($urandom);
        clear_seq(80);
        put_frame(1, 4'd14, 1'b1, 14'b10110010000000, 1'b0, d1);
        rdy_seq[d1+1] = 1'b1;
        put_frame(d1 + 2, 4'd0, la, pa, 1'b0, d2);
        rdy_seq[d2+1] = 1'b1;
        put_frame(d2 + 2, 4'd15, lb, pb, 1'b0, d3);
        run_seq(80);
        n_vec++; if (obs_dout[d1] !== 14'h004D) begin n_err++; $display("FAIL lsb14_dout got %h want 004d", obs_dout[d1]); end
        n_vec++; if (obs_dv[d1] !== 1'b1) begin n_err++; $display("FAIL lsb14_dv got %b want 1", obs_dv[d1]); end
        n_vec++; if (obs_dv[d2-1] !== 1'b0) begin n_err++; $display("FAIL len0_early got %b want 0", obs_dv[d2-1]); end
        n_vec++; if (obs_dv[d2] !== 1'b1) begin n_err++; $display("FAIL len0_dv got %b want 1", obs_dv[d2]); end
        n_vec++; if (obs_dout[d2] !== ref_word(pa, DW, la)) begin n_err++; $display("FAIL len0_dout got %h want %h", obs_dout[d2], ref_word(pa, DW, la)); end
        n_vec++; if (obs_dv[d3-1] !== 1'b0) begin n_err++; $display("FAIL len15_early got %b want 0", obs_dv[d3-1]); end
        n_vec++; if (obs_dout[d3] !== ref_word(pb, DW, lb)) begin n_err++; $display("FAIL len15_dout got %h want %h", obs_dout[d3], ref_word(pb, DW, lb)); end
    endtask

    task automatic test_overrun;
        int d1, d2, pulses;
        for (int pass = 0; pass < 2; pass++) begin
            clear_seq(40);
            put_frame(1, 4'd4, 1'b0, 14'hA, 1'b0, d1);
            put_frame(d1 + 1, 4'd4, 1'b0, 14'h5, 1'b0, d2);
            rdy_seq[d2] = (pass == 1);
            run_seq(40);
            pulses = 0;
            for (int c = 0; c < 40; c++) pulses += int'(obs_ovr[c]);
            n_vec++; if (obs_dv[d2] !== 1'b1) begin n_err++; $display("FAIL ovr_dv pass %0d got %b want 1", pass, obs_dv[d2]); end
            n_vec++; if (obs_dout[d2] !== (pass == 1 ? 14'h5 : 14'hA)) begin n_err++; $display("FAIL ovr_dout pass %0d got %h", pass, obs_dout[d2]); end
            n_vec++; if (pulses !== (pass == 1 ? 0 : 1)) begin n_err++; $display("FAIL ovr_pulses pass %0d got %0d", pass, pulses); end
            n_vec++; if (obs_ovr[d2] !== (pass == 0)) begin n_err++; $display("FAIL ovr_at_done pass %0d got %b", pass, obs_ovr[d2]); end
        end
    endtask

    task automatic test_enable_abort;
        int d0, d, first_dv;
        logic [DW-1:0] pat;
        logic lsb;
        pat = DW'($urandom); lsb = 1'($urandom);
        clear_seq(50);
        put_frame(1, 4'd8, 1'b0, DW'($urandom), 1'b0, d0);
        en_seq[4] = 1'b0;
        for (int c = 5; c < 15; c++) din_seq[c] = 1'b1;
        put_frame(15, 4'd8, lsb, pat, 1'b0, d);
        run_seq(50);
        first_dv = -1;
        for (int c = 49; c >= 0; c--) if (obs_dv[c] === 1'b1) first_dv = c;
        n_vec++; if (obs_busy[3] !== 1'b1) begin n_err++; $display("FAIL abort_busy_pre got %b want 1", obs_busy[3]); end
        n_vec++; if (obs_busy[4] !== 1'b0) begin n_err++; $display("FAIL abort_busy got %b want 0", obs_busy[4]); end
        n_vec++; if (first_dv !== d) begin n_err++; $display("FAIL abort_first_dv got cyc %0d want %0d", first_dv, d); end
        n_vec++; if (obs_dout[d] !== ref_word(pat, 8, lsb)) begin n_err++; $display("FAIL abort_dout got %h want %h", obs_dout[d], ref_word(pat, 8, lsb)); end
    endtask

`ifdef SERIAL_PARALLEL_RX_PARITY_EN
    task automatic test_parity;
        int d, pulses, dvs;
        clear_seq(30);
        put_frame(1, 4'd4, 1'b0, 14'hB, 1'b0, d);
        run_seq(30);
        n_vec++; if (obs_dv[d] !== 1'b1) begin n_err++; $display("FAIL par_ok_dv got %b want 1", obs_dv[d]); end
        n_vec++; if (obs_dout[d] !== 14'hB) begin n_err++; $display("FAIL par_ok_dout got %h want 000b", obs_dout[d]); end
        n_vec++; if (obs_perr[d] !== 1'b0) begin n_err++; $display("FAIL par_ok_perr got %b want 0", obs_perr[d]); end
        clear_seq(30);
        put_frame(1, 4'd4, 1'b0, 14'hB, 1'b1, d);
        run_seq(30);
        pulses = 0; dvs = 0;
        for (int c = 0; c < 30; c++) begin
            pulses += int'(obs_perr[c]);
            dvs    += int'(obs_dv[c]) + int'(obs_ovr[c]);
        end
        n_vec++; if (obs_perr[d] !== 1'b1) begin n_err++; $display("FAIL par_bad_perr got %b want 1", obs_perr[d]); end
        n_vec++; if (pulses !== 1) begin n_err++; $display("FAIL par_bad_pulses got %0d want 1", pulses); end
        n_vec++; if (dvs !== 0) begin n_err++; $display("FAIL par_bad_dv got %0d want 0", dvs); end
    endtask
`endif

    task automatic test_random;
        int c, d, ncyc;
        logic ev, eo, ep;
        logic [DW-1:0] ed;
        logic [LW-1:0] bl;
        logic lsb, bad;
        logic [DW-1:0] pat;
        clear_seq(MAXC);
        for (int k = 0; k < MAXC; k++) begin
            m_done[k] = 1'b0; m_bad[k] = 1'b0; m_word[k] = '0; m_busy[k] = 1'b0;
            rdy_seq[k] = 1'($urandom);
        end
        c = 1;
        while (c < MAXC - 40) begin
            bl  = LW'($urandom);
            lsb = 1'($urandom);
            pat = DW'($urandom);
            bad = (P == 1) && ($urandom_range(3) == 0);
            put_frame(c, bl, lsb, pat, bad, d);
            m_done[d] = 1'b1;
            m_bad[d]  = bad;
            m_word[d] = ref_word(pat, eff_len(bl), lsb);
            for (int k = c; k < d; k++) m_busy[k] = 1'b1;
            c = d + 1 + int'($urandom_range(2));
        end
        ncyc = c + 5;
        run_seq(ncyc);
        ev = 1'b0; ed = '0;
        for (int k = 0; k < ncyc; k++) begin
            eo = 1'b0; ep = 1'b0;
            if (!en_seq[k]) begin
                ev = 1'b0; ed = '0;
            end else if (m_done[k]) begin
                if (m_bad[k]) ep = 1'b1;
                else if (!ev || rdy_seq[k]) begin ev = 1'b1; ed = m_word[k]; end
                else eo = 1'b1;
            end else if (ev && rdy_seq[k]) begin
                ev = 1'b0;
            end
            n_vec++; if (obs_dv[k] !== ev) begin n_err++; $display("FAIL rnd_dv cyc %0d got %b want %b", k, obs_dv[k], ev); end
            n_vec++; if (obs_dout[k] !== ed) begin n_err++; $display("FAIL rnd_dout cyc %0d got %h want %h", k, obs_dout[k], ed); end
            n_vec++; if (obs_ovr[k] !== eo) begin n_err++; $display("FAIL rnd_ovr cyc %0d got %b want %b", k, obs_ovr[k], eo); end
            n_vec++; if (obs_perr[k] !== ep) begin n_err++; $display("FAIL rnd_perr cyc %0d got %b want %b", k, obs_perr[k], ep); end
            n_vec++; if (obs_busy[k] !== m_busy[k]) begin n_err++; $display("FAIL rnd_busy cyc %0d got %b want %b", k, obs_busy[k], m_busy[k]); end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rstn          = 1'b0;
        bus.en        = 1'b0;
        bus.din       = 1'b1;
        bus.bit_lngth = '0;
        bus.lsb_first = 1'b0;
        bus.dready    = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        test_reset();
        test_msb_first();
        test_lsb_clamp();
        test_overrun();
        test_enable_abort();
`ifdef SERIAL_PARALLEL_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/serial_parallel_rx.md
Name: serial_parallel_rx

Overview:
- Framed serial-to-parallel receiver for the ABruTECH bus.
- Detects a start bit, then shifts in a run-time-selectable number of payload bits, MSB- or LSB-first.
- Presents the word right-justified on a valid/ready output register with overrun detection.
- Next-generation deserializer used by master/slave bus ports; generalised in width, frame length and bit order.

Parameters:
- DATA_WIDTH, 14, maximum payload bits and width of dout.
- LEN_WIDTH, 4, width of bit_lngth; must satisfy 2^LEN_WIDTH > DATA_WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- en  input  1  block enable; low = synchronous clear (see Behaviour).
- din  input  1  serial line; idles high.
- bit_lngth  input  LEN_WIDTH  payload bits per frame; sampled at start bit.
- lsb_first  input  1  bit order, sampled at start bit; 0 = MSB-first, 1 = LSB-first.
- dready  input  1  consumer accepts dout when dv_out & dready.
- dout  output  DATA_WIDTH  received word, right-justified, unused upper bits 0.
- dv_out  output  1  dout holds an unconsumed word.
- busy  output  1  frame in progress (state != IDLE).
- overrun  output  1  one-cycle pulse: completed frame dropped because the output register was full.
- parity_err  output  1  one-cycle pulse: parity mismatch; tied 0 when the optional feature is out.

Behaviour:
- Reset (rstn=0, async): state=IDLE, counter=0, shift=0, dout=0, dv_out=0, busy=0, overrun=0, parity_err=0.
- en=0 (sync, every cycle): same values as reset. en=0 mid-frame aborts the frame with no pulse.
- Frame length N = bit_lngth. If bit_lngth==0 or bit_lngth>DATA_WIDTH, N=DATA_WIDTH. N and lsb_first are latched at the start bit; changes mid-frame are ignored.
- FSM states:
  - IDLE: en & din==0 -> SHIFT; counter=0, shift=0.
  - SHIFT: samples din each cycle; counter increments. After the Nth bit -> PARITY if the feature is on, else DONE.
  - PARITY: samples one bit -> DONE.
  - DONE (single cycle): commits or drops the frame -> IDLE.
- Bit placement:
  - MSB-first: first payload bit ends at dout[N-1], last at dout[0].
  - LSB-first: first at dout[0], last at dout[N-1].
  - dout[DATA_WIDTH-1:N] = 0.
- Timing: start bit sampled at edge T; payload at T+1..T+N; DONE at T+N+1. dout/dv_out update at the edge ending DONE, so dv_out is visible from T+N+2. Parity adds one cycle.
- Back-to-back: a new start bit is accepted in the first IDLE cycle after DONE. Minimum frame period is N+2 cycles, N+3 with parity.
- Commit rule in DONE:
  - Commit if dv_out==0, or dv_out & dready in the same cycle (simultaneous consume+load): dout=new word, dv_out=1.
  - Otherwise drop the new word, keep the old dout/dv_out, and pulse overrun for one cycle.
- dv_out & dready with no commit: dv_out->0 next cycle; dout holds its value.
- din high in IDLE: no action. Line glitches after the start bit are not filtered.
- busy=1 in SHIFT, PARITY and DONE.

Optional Feature:
- Macro: SERIAL_PARALLEL_RX_PARITY_EN.
- Defined:
  - After the N payload bits, one even-parity bit is received; XOR of payload and parity must be 0.
  - Mismatch: frame dropped, parity_err pulses one cycle in the cycle after DONE, dv_out/dout unchanged. No overrun is flagged for that frame.
- Undefined: no PARITY state; parity_err is constant 0.

Test Plan:
- Reset/idle: rstn low mid-frame, din idle high -> all outputs 0; release, 20 idle cycles -> dv_out stays 0, busy 0.
- MSB-first 8-bit: bit_lngth=8, lsb_first=0, start then 1,0,1,1,0,0,1,0 -> dout=14'h00B2; dv_out rises exactly N+2 cycles after start; holds until dready.
- LSB-first, max and clamped length: bit_lngth=14, same pattern -> dout=14'h004D; bit_lngth=0 and bit_lngth=15 -> 14 bits received.
- Overrun and simultaneous: dready=0, two back-to-back 4-bit frames 0xA then 0x5 -> dout=0xA, overrun pulses once. Repeat with dready=1 in the second DONE cycle -> dout=0x5, no overrun.
- Enable abort: en dropped at bit 3 of 8 -> busy 0, no dv_out; en restored, a full frame is received correctly.
- Parity (macro on): 4-bit 0xB with parity 1 -> dv_out, dout=0xB; parity 0 -> parity_err one-cycle pulse, dv_out stays 0.
